// File: rtl/bshift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   MODE_*        : raw encodings of the in_mode field (5..7 reserved)
//   bshift_mode_t : decoded shift operation carried down the pipe
//   bshift_nstg() : number of register stages for a given width / levels-per-stage
package bshift_pkg;

  localparam int unsigned MODEW = 3;

  localparam logic [MODEW-1:0] MODE_SLL = 3'd0;
  localparam logic [MODEW-1:0] MODE_SRL = 3'd1;
  localparam logic [MODEW-1:0] MODE_SRA = 3'd2;
  localparam logic [MODEW-1:0] MODE_ROL = 3'd3;
  localparam logic [MODEW-1:0] MODE_ROR = 3'd4;

  typedef enum logic [MODEW-1:0] {
    BSH_SLL = MODE_SLL,
    BSH_SRL = MODE_SRL,
    BSH_SRA = MODE_SRA,
    BSH_ROL = MODE_ROL,
    BSH_ROR = MODE_ROR
  } bshift_mode_t;

  // ceil(log2(width) / lps)
  function automatic int unsigned bshift_nstg(input int unsigned width, input int unsigned lps);
    return (int'($clog2(width)) + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/bshift_level.sv
// One mux level of the barrel shifter: shifts by SH when sel=1.
// Build option: PIPE_BSHIFT_STICKY_EN enables right-shift sticky accumulation.
//   data_in/data_out     : operand before/after this level
//   sticky_in/sticky_out : running OR of bits discarded by SRL/SRA
//   sel                  : apply this level's shift
//   mode                 : decoded operation
module bshift_level
  import bshift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SH    = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             sticky_in,
  input  logic             sel,
  input  bshift_mode_t     mode,
  output logic [WIDTH-1:0] data_out,
  output logic             sticky_out
);

  // Shift mux; fill bits depend on operation
  always_comb begin
    data_out = data_in;
    if (sel) begin
      case (mode)
        BSH_SLL: data_out = data_in << SH;
        BSH_SRL: data_out = data_in >> SH;
        BSH_SRA: data_out = $unsigned($signed(data_in) >>> SH);
        BSH_ROL: data_out = {data_in[WIDTH-SH-1:0], data_in[WIDTH-1:WIDTH-SH]};
        BSH_ROR: data_out = {data_in[SH-1:0], data_in[WIDTH-1:SH]};
        default: data_out = data_in;
      endcase
    end
  end

`ifdef PIPE_BSHIFT_STICKY_EN
  // Right shifts drop the low SH bits into the sticky
  always_comb begin
    sticky_out = sticky_in;
    if (sel && (mode == BSH_SRL || mode == BSH_SRA)) begin
      sticky_out = sticky_in | (|data_in[SH-1:0]);
    end
  end
`else
  // Chain is fed constant 0 from the top and folds away
  assign sticky_out = sticky_in;
`endif

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined log-depth barrel shifter (SLL/SRL/SRA/ROL/ROR) with tag sideband
// and valid/ready handshake; a register boundary follows every LPS mux levels.
// Build option: PIPE_BSHIFT_STICKY_EN builds the right-shift sticky; otherwise out_sticky is 0.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : input handshake
//   in_data, in_amt, in_mode     : operand, unsigned shift amount, operation
//   in_tag                       : opaque sideband, returned with its result
//   out_valid/out_ready          : output handshake
//   out_data, out_sticky, out_tag: result, OR of discarded bits, tag
module pipe_barrel_shifter
  import bshift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMTW  = 8,
  parameter int unsigned LPS   = 2,
  parameter int unsigned TAGW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]  in_amt,
  input  logic [MODEW-1:0] in_mode,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic [TAGW-1:0]  out_tag
);

  localparam int unsigned LOGW = $clog2(WIDTH);
  localparam int unsigned NSTG = bshift_nstg(WIDTH, LPS);
  localparam int unsigned CW   = AMTW + 1;

  // Global stall: every stage moves together
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~rst;

  // Stage-0 decode: mode, effective amount, saturation of oversize shifts
  logic [WIDTH-1:0] d0_data;
  logic             d0_sticky;
  logic [LOGW-1:0]  d0_eff;
  bshift_mode_t     d0_mode;
  logic             d0_sat;

  always_comb begin
    d0_data   = in_data;
    d0_sticky = 1'b0;
    d0_eff    = in_amt[LOGW-1:0];
    d0_mode   = bshift_mode_t'(in_mode);
    d0_sat    = (CW'(in_amt) >= CW'(WIDTH));
    case (in_mode)
      MODE_SLL: begin
        if (d0_sat) begin
          d0_data = '0;
          d0_eff  = '0;
        end
      end
      MODE_SRL, MODE_SRA: begin
        if (d0_sat) begin
          d0_data = (in_mode == MODE_SRA) ? {WIDTH{in_data[WIDTH-1]}} : '0;
          d0_eff  = '0;
`ifdef PIPE_BSHIFT_STICKY_EN
          d0_sticky = |in_data;
`endif
        end
      end
      MODE_ROL, MODE_ROR: ;  // amount wraps modulo WIDTH via the low bits
      default: begin
        // Reserved: pass operand through unchanged
        d0_mode = BSH_SLL;
        d0_eff  = '0;
      end
    endcase
  end

  // Pipeline stage registers
  logic [WIDTH-1:0] st_data   [NSTG];
  logic             st_sticky [NSTG];
  logic [LOGW-1:0]  st_eff    [NSTG];
  bshift_mode_t     st_mode   [NSTG];
  logic [TAGW-1:0]  st_tag    [NSTG];
  logic             st_valid  [NSTG];

  // Per-level mux chain wiring
  logic [WIDTH-1:0] lv_din   [LOGW];
  logic [WIDTH-1:0] lv_dout  [LOGW];
  logic             lv_sin   [LOGW];
  logic             lv_sout  [LOGW];
  logic             lv_sel   [LOGW];
  bshift_mode_t     lv_mode  [LOGW];

  for (genvar k = 0; k < LOGW; k++) begin : g_lvl
    localparam int unsigned S = k / LPS;

    // Data source: decode, previous stage register, or previous level
    if (k == 0) begin : g_src_dec
      assign lv_din[k] = d0_data;
      assign lv_sin[k] = d0_sticky;
    end else if ((k % LPS) == 0) begin : g_src_reg
      assign lv_din[k] = st_data[S-1];
      assign lv_sin[k] = st_sticky[S-1];
    end else begin : g_src_lvl
      assign lv_din[k] = lv_dout[k-1];
      assign lv_sin[k] = lv_sout[k-1];
    end

    // Control source: whichever register feeds this stage
    if (S == 0) begin : g_ctl_dec
      assign lv_mode[k] = d0_mode;
      assign lv_sel[k]  = d0_eff[k];
    end else begin : g_ctl_reg
      assign lv_mode[k] = st_mode[S-1];
      assign lv_sel[k]  = st_eff[S-1][k];
    end

    bshift_level #(
      .WIDTH (WIDTH),
      .SH    (1 << k)
    ) u_level (
      .data_in    (lv_din[k]),
      .sticky_in  (lv_sin[k]),
      .sel        (lv_sel[k]),
      .mode       (lv_mode[k]),
      .data_out   (lv_dout[k]),
      .sticky_out (lv_sout[k])
    );
  end

  // Next-value sources for each stage register
  logic [WIDTH-1:0] src_data   [NSTG];
  logic             src_sticky [NSTG];
  logic [LOGW-1:0]  src_eff    [NSTG];
  bshift_mode_t     src_mode   [NSTG];
  logic [TAGW-1:0]  src_tag    [NSTG];
  logic             src_valid  [NSTG];

  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    localparam int unsigned LAST = ((s + 1) * LPS < LOGW) ? ((s + 1) * LPS - 1) : (LOGW - 1);

    assign src_data[s]   = lv_dout[LAST];
    assign src_sticky[s] = lv_sout[LAST];

    if (s == 0) begin : g_first
      assign src_valid[s] = in_valid;
      assign src_tag[s]   = in_tag;
      assign src_mode[s]  = d0_mode;
      assign src_eff[s]   = d0_eff;
    end else begin : g_next
      assign src_valid[s] = st_valid[s-1];
      assign src_tag[s]   = st_tag[s-1];
      assign src_mode[s]  = st_mode[s-1];
      assign src_eff[s]   = st_eff[s-1];
    end
  end

  // Stage registers: cleared by reset, load only on advance
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSTG; s++) begin
      if (rst) begin
        st_valid[s]  <= 1'b0;
        st_data[s]   <= '0;
        st_sticky[s] <= 1'b0;
        st_tag[s]    <= '0;
        st_eff[s]    <= '0;
        st_mode[s]   <= BSH_SLL;
      end else if (adv) begin
        st_valid[s]  <= src_valid[s];
        st_data[s]   <= src_data[s];
        st_sticky[s] <= src_sticky[s];
        st_tag[s]    <= src_tag[s];
        st_eff[s]    <= src_eff[s];
        st_mode[s]   <= src_mode[s];
      end
    end
  end

  // Last stage is the output register
  assign out_valid  = st_valid[NSTG-1];
  assign out_data   = st_data[NSTG-1];
  assign out_sticky = st_sticky[NSTG-1];
  assign out_tag    = st_tag[NSTG-1];

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
`timescale 1ns/1ps
module tb_pipe_barrel_shifter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned AMTW  = 8;
  localparam int unsigned LPS   = 2;
  localparam int unsigned TAGW  = 8;
  localparam int          NSTG  = 3;

`ifdef PIPE_BSHIFT_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [AMTW-1:0]  in_amt = '0;
  logic [2:0]       in_mode = '0;
  logic [TAGW-1:0]  in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;
  logic [TAGW-1:0]  out_tag;

  pipe_barrel_shifter #(
    .WIDTH (WIDTH),
    .AMTW  (AMTW),
    .LPS   (LPS),
    .TAGW  (TAGW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  a;
    logic [2:0]  m;
    logic [31:0] exp_d;
    logic        exp_s;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic [7:0]  t;
  } res_t;

  res_t sb[$];
  res_t exp_r;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   rnd_done = 1'b0;

  logic        held = 1'b0;
  logic [31:0] held_d;
  logic        held_s;
  logic [7:0]  held_t;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: straight from the operation definitions, not level by level
  function automatic void ref_model(input logic [31:0] d, input logic [7:0] a, input logic [2:0] m,
                                    output logic [31:0] r, output logic s);
    logic [63:0] dd;
    logic [63:0] mask;
    logic        lost;
    int          e;
    dd = {d, d};
    e  = int'(a) % 32;
    r  = d;
    s  = 1'b0;
    if (a >= 8'd32) lost = |d;
    else begin
      mask = (64'd1 << a) - 64'd1;
      lost = |({32'd0, d} & mask);
    end
    case (m)
      3'd0: r = (a >= 8'd32) ? 32'd0 : (d << a);
      3'd1: begin r = (a >= 8'd32) ? 32'd0 : (d >> a); s = lost; end
      3'd2: begin r = (a >= 8'd32) ? {32{d[31]}} : 32'($signed(d) >>> a); s = lost; end
      3'd3: r = 32'((dd << e) >> 32);
      3'd4: r = 32'(dd >> e);
      default: r = d;
    endcase
    s = s & STICKY_ON;
  endfunction

  // Output monitor: scoreboard pop plus stall-stability check
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        checks++;
        if (out_data !== held_d || out_sticky !== held_s || out_tag !== held_t) begin
          errors++;
          $display("FAIL stall_stable got d=%h s=%0b t=%0d required d=%h s=%0b t=%0d",
                   out_data, out_sticky, out_tag, held_d, held_s, held_t);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got d=%h t=%0d required no result", out_data, out_tag);
        end else begin
          exp_r = sb.pop_front();
          if (out_data !== exp_r.d || out_sticky !== exp_r.s || out_tag !== exp_r.t) begin
            errors++;
            $display("FAIL result got d=%h s=%0b t=%0d required d=%h s=%0b t=%0d",
                     out_data, out_sticky, out_tag, exp_r.d, exp_r.s, exp_r.t);
          end
        end
      end
      held   = out_valid && !out_ready;
      held_d = out_data;
      held_s = out_sticky;
      held_t = out_tag;
    end
  end

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // Present one op, wait (bounded) for acceptance, enqueue its expected result
  task automatic drive_op(input logic [31:0] d, input logic [7:0] a, input logic [2:0] m,
                          input logic [7:0] t, input logic [31:0] ed, input logic es);
    bit   ok;
    res_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    in_tag   = t;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      e.d = ed; e.s = es; e.t = t;
      sb.push_back(e);
      last_acc = cyc;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tag=%0d got in_ready=%0b required 1", t, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_rand(input logic [31:0] d, input logic [7:0] a, input logic [2:0] m, input logic [7:0] t);
    logic [31:0] r;
    logic        s;
    ref_model(d, a, m, r, s);
    drive_op(d, a, m, t, r, s);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    check1("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end

  vec_t vt[16];
  int   lat;

  initial begin
    vt[0]  = '{32'h80000001, 8'd1,   3'd1, 32'h40000000, 1'b1};
    vt[1]  = '{32'h80000000, 8'd40,  3'd2, 32'hFFFFFFFF, 1'b1};
    vt[2]  = '{32'h12345678, 8'd32,  3'd1, 32'h00000000, 1'b1};
    vt[3]  = '{32'h00000001, 8'd31,  3'd0, 32'h80000000, 1'b0};
    vt[4]  = '{32'h00000003, 8'd33,  3'd4, 32'h80000001, 1'b0};
    vt[5]  = '{32'h0000000C, 8'd30,  3'd4, 32'h00000030, 1'b0};
    vt[6]  = '{32'h00000001, 8'd29,  3'd3, 32'h20000000, 1'b0};
    vt[7]  = '{32'hDEADBEEF, 8'd32,  3'd3, 32'hDEADBEEF, 1'b0};
    vt[8]  = '{32'hDEADBEEF, 8'd0,   3'd1, 32'hDEADBEEF, 1'b0};
    vt[9]  = '{32'hCAFEF00D, 8'd7,   3'd5, 32'hCAFEF00D, 1'b0};
    vt[10] = '{32'h80000010, 8'd4,   3'd2, 32'hF8000001, 1'b0};
    vt[11] = '{32'h7FFFFFFF, 8'd255, 3'd2, 32'h00000000, 1'b1};
    vt[12] = '{32'h0000FFFF, 8'd16,  3'd0, 32'hFFFF0000, 1'b0};
    vt[13] = '{32'h00000100, 8'd9,   3'd1, 32'h00000000, 1'b1};
    vt[14] = '{32'h80000000, 8'd1,   3'd3, 32'h00000001, 1'b0};
    vt[15] = '{32'h00001234, 8'd40,  3'd7, 32'h00001234, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check1("rst_out_valid", 32'(out_valid), 32'd0);
    check1("rst_out_data", out_data, 32'd0);
    check1("rst_out_tag", 32'(out_tag), 32'd0);
    check1("rst_out_sticky", 32'(out_sticky), 32'd0);
    check1("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency of a single op into an empty pipe
    drive_op(vt[0].d, vt[0].a, vt[0].m, 8'd0, vt[0].exp_d, vt[0].exp_s & STICKY_ON);
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) begin lat = cyc - last_acc; break; end
    end
    check1("latency", 32'(lat), 32'(NSTG));
    drain();
    @(posedge clk);
    #1;

    // Directed vectors back-to-back
    for (int i = 1; i < 16; i++)
      drive_op(vt[i].d, vt[i].a, vt[i].m, 8'(i), vt[i].exp_d, vt[i].exp_s & STICKY_ON);
    drain();
    @(posedge clk);
    #1;

    // Six ops into a stalled output
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          drive_rand(32'h11111111 * i, 8'(i * 3), 3'(i % 5), 8'(i));
      end
      begin
        for (int n = 0; n < 20; n++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        check1("stall_out_valid", 32'(out_valid), 32'd1);
        check1("stall_in_ready", 32'(in_ready), 32'd0);
        check1("stall_held_ops", 32'(sb.size()), 32'd3);
        for (int n = 0; n < 3; n++) begin
          @(negedge clk);
          check1("stall_in_ready_hold", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk);
    #1;

    // Reset with two ops in flight
    drive_rand(32'hA5A5A5A5, 8'd3, 3'd1, 8'd77);
    drive_rand(32'h5A5A5A5A, 8'd5, 3'd3, 8'd78);
    rst = 1'b1;
    @(negedge clk);
    check1("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check1("post_rst_out_valid", 32'(out_valid), 32'd0);
    check1("post_rst_out_data", out_data, 32'd0);
    check1("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check1("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Random ops with random gaps and backpressure
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          logic [7:0] a;
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
          drive_rand($urandom, a, 3'($urandom_range(0, 7)), 8'(i));
        end
        rnd_done = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
